// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the UART receiver
interface uart_rx_if;
    logic       rx_i;
    logic [7:0] d_o;
    logic       v_o;
    logic       frame_err_o;
    logic       busy_o;

    // Receiver side: samples the line, drives the byte and status strobes
    modport slave (
        input  rx_i,
        output d_o,
        output v_o,
        output frame_err_o,
        output busy_o
    );

    // Line driver / byte consumer side
    modport master (
        output rx_i,
        input  d_o,
        input  v_o,
        input  frame_err_o,
        input  busy_o
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, LSB first, mid-bit sampling; optional UART_RX_MAJORITY_EN 2-of-3 vote
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic      clk,
    input  logic      resetn,
    uart_rx_if.slave  rx_port
);
    localparam int N  = CLKS_PER_BIT;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] N_LAST = CW'(N - 1);
    localparam logic [CW-1:0] H_LAST = CW'(H - 1);

    typedef enum logic [2:0] {
        S_WAIT_HIGH = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_STOP      = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            s1_q;
    logic            rx_s_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      d_q, d_d;
    logic            v_q, v_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
    logic            sample_w;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] N_V0 = CW'(N - 3);
    localparam logic [CW-1:0] N_V1 = CW'(N - 2);
    localparam logic [CW-1:0] H_V0 = CW'(H - 3);
    localparam logic [CW-1:0] H_V1 = CW'(H - 2);

    logic [1:0] vote_q, vote_d;

    // Collect the two early votes; the third is the live sample at the decision cycle
    always_comb begin
        vote_d = vote_q;
        if (state_q == S_START) begin
            if (cnt_q == H_V0) vote_d[0] = rx_s_q;
            if (cnt_q == H_V1) vote_d[1] = rx_s_q;
        end else if (state_q == S_DATA || state_q == S_STOP) begin
            if (cnt_q == N_V0) vote_d[0] = rx_s_q;
            if (cnt_q == N_V1) vote_d[1] = rx_s_q;
        end
    end

    // Vote registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) vote_q <= 2'b11;
        else         vote_q <= vote_d;
    end

    // 2-of-3 majority so a single-cycle glitch inside the window is ignored
    always_comb begin
        sample_w = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
    end
`else
    // Single sample taken at the decision cycle
    always_comb begin
        sample_w = rx_s_q;
    end
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q   <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            s1_q   <= rx_port.rx_i;
            rx_s_q <= s1_q;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_WAIT_HIGH;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'h00;
            d_q       <= 8'h00;
            v_q       <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            d_q       <= d_d;
            v_q       <= v_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and output logic; the timer is cleared whenever a state is (re)entered
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        d_d       = d_q;
        v_d       = 1'b0;
        ferr_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            S_WAIT_HIGH: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                if (rx_s_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                cnt_d     = '0;
                busy_d    = 1'b0;
                bit_idx_d = 3'd0;
                if (!rx_s_q) begin
                    state_d = S_START;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == H_LAST) begin
                    cnt_d = '0;
                    if (!sample_w) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == N_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {sample_w, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == N_LAST) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    if (sample_w) begin
                        d_d     = shreg_q;
                        v_d     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            default: begin
                state_d = S_WAIT_HIGH;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign rx_port.d_o         = d_q;
    assign rx_port.v_o         = v_q;
    assign rx_port.frame_err_o = ferr_q;
    assign rx_port.busy_o      = busy_q;
endmodule
